// File: rtl/regfile_dbg_bridge.sv
// ---------------------------------------------------------------------------
// regfile_dbg_bridge
//
// Debug bridge between a UART byte stream and the core register file. It
// accepts read/write commands from the UART receiver, freezes the core with a
// stall request/acknowledge pair, performs the access on the photon ports and
// streams the response back to the UART transmitter.
//
// Command byte: bit7 = 1 write / 0 read, bits6:5 must be 00, bits4:0 = index.
// A write is followed by 4 data bytes, least-significant byte first. A write
// answers ACK_BYTE, a read answers 4 data bytes LSB first, a malformed command
// answers NAK_BYTE and sets the sticky err flag.
//
// Ports:
//   clk, Rst_n                 clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_ready  incoming byte stream (valid/ready)
//   tx_data/tx_valid/tx_ready  outgoing byte stream (valid/ready)
//   stall_req/stall_ack        core freeze handshake
//   adr_photon_rs1             register read address (0 when not reading)
//   photon_rs1_data            combinational read data
//   photon_regwrite            one-cycle write strobe
//   addr_corereg_photon        write address
//   photon_data_out            write data
//   busy                       any state other than IDLE
//   err                        sticky error flag, cleared only by reset
//
// Optional feature macro: REGBRIDGE_TIMEOUT_EN. When defined, a command whose
// data bytes stop arriving for TIMEOUT_CYCLES cycles is abandoned with a NAK.
// ---------------------------------------------------------------------------
module regfile_dbg_bridge #(
   parameter logic [7:0] ACK_BYTE       = 8'hAA,
   parameter logic [7:0] NAK_BYTE       = 8'hEE,
   parameter int         TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        Rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        stall_req,
   input  logic        stall_ack,
   output logic [4:0]  adr_photon_rs1,
   input  logic [31:0] photon_rs1_data,
   output logic        photon_regwrite,
   output logic [4:0]  addr_corereg_photon,
   output logic [31:0] photon_data_out,
   output logic        busy,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE,
      GETD,
      REQ,
      WR,
      RD,
      SEND,
      RESP
   } bridgeState_t;

   bridgeState_t state;
   logic         isWrite;
   logic [4:0]   regIndex;
   logic [31:0]  dataWord;
   logic [1:0]   byteCount;
   logic [23:0]  shiftReg;
   logic [2:0]   sendCount;

`ifdef REGBRIDGE_TIMEOUT_EN
   localparam int GapWidth = $clog2(TIMEOUT_CYCLES + 1);
   logic [GapWidth-1:0] gapCount;
`endif

   // Single state machine; every output is a register that is set up on the
   // transition into the state that owns it. The register-file strobes and
   // the read address default back to 0 each cycle so they last exactly one
   // cycle. tx_data holds the byte currently offered, and shiftReg keeps the
   // remaining upper bytes of a read result.
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state               <= IDLE;
         rx_ready            <= 1'b1;
         tx_data             <= 8'h00;
         tx_valid            <= 1'b0;
         stall_req           <= 1'b0;
         adr_photon_rs1      <= 5'd0;
         photon_regwrite     <= 1'b0;
         addr_corereg_photon <= 5'd0;
         photon_data_out     <= 32'd0;
         busy                <= 1'b0;
         err                 <= 1'b0;
         isWrite             <= 1'b0;
         regIndex            <= 5'd0;
         dataWord            <= 32'd0;
         byteCount           <= 2'd0;
         shiftReg            <= 24'd0;
         sendCount           <= 3'd0;
`ifdef REGBRIDGE_TIMEOUT_EN
         gapCount            <= '0;
`endif
      end else begin
         photon_regwrite     <= 1'b0;
         adr_photon_rs1      <= 5'd0;
         addr_corereg_photon <= 5'd0;
         photon_data_out     <= 32'd0;

         case (state)
            IDLE: begin
               if (rx_valid && rx_ready) begin
                  regIndex <= rx_data[4:0];
                  isWrite  <= rx_data[7];
                  busy     <= 1'b1;
                  if (rx_data[6:5] != 2'b00) begin
                     state    <= RESP;
                     tx_data  <= NAK_BYTE;
                     tx_valid <= 1'b1;
                     rx_ready <= 1'b0;
                     err      <= 1'b1;
                  end else if (rx_data[7]) begin
                     state     <= GETD;
                     byteCount <= 2'd0;
`ifdef REGBRIDGE_TIMEOUT_EN
                     gapCount  <= '0;
`endif
                  end else begin
                     state     <= REQ;
                     stall_req <= 1'b1;
                     rx_ready  <= 1'b0;
                  end
               end
            end

            // Data bytes arrive LSB first, so shifting right leaves the first
            // byte in bits 7:0 after the fourth byte.
            GETD: begin
               if (rx_valid && rx_ready) begin
                  dataWord  <= {rx_data, dataWord[31:8]};
                  byteCount <= byteCount + 2'd1;
`ifdef REGBRIDGE_TIMEOUT_EN
                  gapCount  <= '0;
`endif
                  if (byteCount == 2'd3) begin
                     state     <= REQ;
                     stall_req <= 1'b1;
                     rx_ready  <= 1'b0;
                  end
               end
`ifdef REGBRIDGE_TIMEOUT_EN
               else if (gapCount == GapWidth'(TIMEOUT_CYCLES - 1)) begin
                  state    <= RESP;
                  dataWord <= 32'd0;
                  tx_data  <= NAK_BYTE;
                  tx_valid <= 1'b1;
                  rx_ready <= 1'b0;
                  err      <= 1'b1;
               end else begin
                  gapCount <= gapCount + 1'b1;
               end
`endif
            end

            REQ: begin
               if (stall_ack) begin
                  if (isWrite) begin
                     state               <= WR;
                     photon_regwrite     <= 1'b1;
                     addr_corereg_photon <= regIndex;
                     photon_data_out     <= dataWord;
                  end else begin
                     state          <= RD;
                     adr_photon_rs1 <= regIndex;
                  end
               end
            end

            WR: begin
               state     <= RESP;
               stall_req <= 1'b0;
               tx_data   <= ACK_BYTE;
               tx_valid  <= 1'b1;
            end

            // Read data is valid while adr_photon_rs1 points at the register,
            // i.e. during this cycle; capture it on the way out.
            RD: begin
               state     <= SEND;
               stall_req <= 1'b0;
               tx_data   <= photon_rs1_data[7:0];
               shiftReg  <= photon_rs1_data[31:8];
               sendCount <= 3'd4;
               tx_valid  <= 1'b1;
            end

            SEND: begin
               if (tx_ready) begin
                  if (sendCount == 3'd1) begin
                     state    <= IDLE;
                     tx_valid <= 1'b0;
                     rx_ready <= 1'b1;
                     busy     <= 1'b0;
                  end else begin
                     tx_data  <= shiftReg[7:0];
                     shiftReg <= {8'h00, shiftReg[23:8]};
                  end
                  sendCount <= sendCount - 3'd1;
               end
            end

            RESP: begin
               if (tx_ready) begin
                  state    <= IDLE;
                  tx_valid <= 1'b0;
                  rx_ready <= 1'b1;
                  busy     <= 1'b0;
               end
            end

            default: begin
               state     <= IDLE;
               tx_valid  <= 1'b0;
               stall_req <= 1'b0;
               rx_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dbg_bridge.sv
// ---------------------------------------------------------------------------
// tb_regfile_dbg_bridge
//
// Self-checking bench for regfile_dbg_bridge. A simple register-file model
// answers reads and absorbs write strobes; a separate command-level model
// predicts the response bytes, the write strobes and the err flag for every
// command, and directed plus randomized command sequences are compared
// against it.
// ---------------------------------------------------------------------------
module tb_regfile_dbg_bridge;

   logic        clk = 1'b0;
   logic        Rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        stall_req;
   logic        stall_ack;
   logic [4:0]  adr_photon_rs1;
   logic [31:0] photon_rs1_data;
   logic        photon_regwrite;
   logic [4:0]  addr_corereg_photon;
   logic [31:0] photon_data_out;
   logic        busy;
   logic        err;

   localparam logic [7:0] AckByte = 8'hAA;
   localparam logic [7:0] NakByte = 8'hEE;

   int checkCount = 0;
   int errorCount = 0;

   // Register-file environment: index 0 always reads as 0.
   logic [31:0] rf [32];

   // Command-level reference model.
   logic [31:0] expRegs [32];
   logic        expErr;
   logic [7:0]  expTx [$];
   logic [36:0] expWr [$];

   // Observations collected by the monitor.
   logic [7:0]  txGot [$];
   logic [36:0] wrGot [$];
   logic        stallSeen;
   logic        holding = 1'b0;
   logic [7:0]  heldByte = 8'h00;
   logic        xferPending = 1'b0;

   int          txDelay = 0;
   int          holdCnt = 0;
   logic        ackRandom = 1'b0;

   always #5 clk = ~clk;

   regfile_dbg_bridge #(
      .ACK_BYTE       (AckByte),
      .NAK_BYTE       (NakByte),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk                 (clk),
      .Rst_n               (Rst_n),
      .rx_data             (rx_data),
      .rx_valid            (rx_valid),
      .rx_ready            (rx_ready),
      .tx_data             (tx_data),
      .tx_valid            (tx_valid),
      .tx_ready            (tx_ready),
      .stall_req           (stall_req),
      .stall_ack           (stall_ack),
      .adr_photon_rs1      (adr_photon_rs1),
      .photon_rs1_data     (photon_rs1_data),
      .photon_regwrite     (photon_regwrite),
      .addr_corereg_photon (addr_corereg_photon),
      .photon_data_out     (photon_data_out),
      .busy                (busy),
      .err                 (err)
   );

   assign photon_rs1_data = (adr_photon_rs1 == 5'd0) ? 32'd0 : rf[adr_photon_rs1];

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Monitor sampled mid-cycle: records transfers that will occur on the
   // next rising edge and checks that an offered byte stays put while held.
   always @(negedge clk) begin
      if (Rst_n) begin
         if (holding) begin
            checkOutput("txHeldValid", 64'(tx_valid), 64'd1);
            checkOutput("txHeldData", 64'(tx_data), 64'(heldByte));
         end
         if (tx_valid) checkOutput("rxBlockedDuringTx", 64'(rx_ready), 64'd0);
         if (tx_valid && tx_ready) txGot.push_back(tx_data);
         if (photon_regwrite) begin
            wrGot.push_back({addr_corereg_photon, photon_data_out});
            if (addr_corereg_photon != 5'd0) rf[addr_corereg_photon] = photon_data_out;
         end
         if (stall_req) stallSeen = 1'b1;
         holding     = tx_valid && !tx_ready;
         heldByte    = tx_data;
         xferPending = tx_valid && tx_ready;
      end else begin
         holding     = 1'b0;
         xferPending = 1'b0;
      end
   end

   // Transmitter model: holds tx_ready low for txDelay cycles before each byte.
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (xferPending) holdCnt = 0;
         if (tx_valid && holdCnt < txDelay) begin
            tx_ready = 1'b0;
            holdCnt++;
         end else begin
            tx_ready = 1'b1;
         end
      end
   end

   // Core model in random mode: acknowledges the stall most of the time.
   always @(posedge clk) begin
      #1;
      if (ackRandom) stall_ack = ($urandom_range(0, 3) != 0);
   end

   // Predict the outcome of one command from the command-byte rules.
   task automatic modelCommand(input logic [7:0] cmd, input logic [31:0] word);
      logic [31:0] value;
      if (cmd[6:5] != 2'b00) begin
         expTx.push_back(NakByte);
         expErr = 1'b1;
      end else if (cmd[7]) begin
         expWr.push_back({cmd[4:0], word});
         if (cmd[4:0] != 5'd0) expRegs[cmd[4:0]] = word;
         expTx.push_back(AckByte);
      end else begin
         value = (cmd[4:0] == 5'd0) ? 32'd0 : expRegs[cmd[4:0]];
         for (int i = 0; i < 4; i++) expTx.push_back(value[8*i +: 8]);
      end
   endtask

   // Offer one byte to the bridge; entered and left just after a rising edge.
   task automatic applyStimulus(input logic [7:0] b);
      int n;
      n        = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      while (!rx_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) checkOutput("rxAcceptTimeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (busy) checkOutput("idleTimeout", 64'd1, 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic compareResults();
      checkOutput("txCount", 64'(txGot.size()), 64'(expTx.size()));
      for (int i = 0; i < txGot.size() && i < expTx.size(); i++)
         checkOutput("txByte", 64'(txGot[i]), 64'(expTx[i]));
      checkOutput("writeCount", 64'(wrGot.size()), 64'(expWr.size()));
      for (int i = 0; i < wrGot.size() && i < expWr.size(); i++)
         checkOutput("writeAddrData", 64'(wrGot[i]), 64'(expWr[i]));
      checkOutput("err", 64'(err), 64'(expErr));
      checkOutput("idleRxReady", 64'(rx_ready), 64'd1);
      checkOutput("idleStallReq", 64'(stall_req), 64'd0);
      txGot.delete();
      expTx.delete();
      wrGot.delete();
      expWr.delete();
   endtask

   task automatic runCommand(input logic [7:0] cmd, input logic [31:0] word);
      modelCommand(cmd, word);
      stallSeen = 1'b0;
      applyStimulus(cmd);
      if (cmd[6:5] == 2'b00 && cmd[7])
         for (int i = 0; i < 4; i++) applyStimulus(word[8*i +: 8]);
      waitIdle();
      if (cmd[6:5] != 2'b00) checkOutput("noStallOnNak", 64'(stallSeen), 64'd0);
      compareResults();
   endtask

   task automatic checkResetOutputs();
      checkOutput("rstRxReady", 64'(rx_ready), 64'd1);
      checkOutput("rstTxValid", 64'(tx_valid), 64'd0);
      checkOutput("rstTxData", 64'(tx_data), 64'd0);
      checkOutput("rstStallReq", 64'(stall_req), 64'd0);
      checkOutput("rstAdrRs1", 64'(adr_photon_rs1), 64'd0);
      checkOutput("rstRegWrite", 64'(photon_regwrite), 64'd0);
      checkOutput("rstWrAddr", 64'(addr_corereg_photon), 64'd0);
      checkOutput("rstWrData", 64'(photon_data_out), 64'd0);
      checkOutput("rstBusy", 64'(busy), 64'd0);
      checkOutput("rstErr", 64'(err), 64'd0);
   endtask

   initial begin
      logic [7:0]  cmd;
      logic [31:0] word;
      int          kind;

      Rst_n     = 1'b0;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      stall_ack = 1'b1;
      expErr    = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rf[i]      = $urandom;
         expRegs[i] = rf[i];
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetOutputs();
      @(posedge clk);
      #1;
      Rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] write then read");
      runCommand(8'h85, 32'h12345678);
      modelCommand(8'h05, 32'd0);
      applyStimulus(8'h05);
      @(negedge clk);
      checkOutput("latReqStall", 64'(stall_req), 64'd1);
      checkOutput("latReqAdr", 64'(adr_photon_rs1), 64'd0);
      @(negedge clk);
      checkOutput("latRdAdr", 64'(adr_photon_rs1), 64'd5);
      checkOutput("latRdTxValid", 64'(tx_valid), 64'd0);
      @(negedge clk);
      checkOutput("latSendTxValid", 64'(tx_valid), 64'd1);
      checkOutput("latSendAdr", 64'(adr_photon_rs1), 64'd0);
      checkOutput("latSendStall", 64'(stall_req), 64'd0);
      @(posedge clk);
      #1;
      waitIdle();
      compareResults();

      $display("[TB] stall handshake");
      stall_ack = 1'b0;
      modelCommand(8'h02, 32'd0);
      applyStimulus(8'h02);
      repeat (20) begin
         @(negedge clk);
         checkOutput("stallHeldReq", 64'(stall_req), 64'd1);
         checkOutput("stallHeldAdr", 64'(adr_photon_rs1), 64'd0);
         checkOutput("stallHeldTx", 64'(tx_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      stall_ack = 1'b1;
      @(negedge clk);
      checkOutput("ackRiseAdr", 64'(adr_photon_rs1), 64'd0);
      @(negedge clk);
      checkOutput("ackRdAdr", 64'(adr_photon_rs1), 64'd2);
      @(negedge clk);
      checkOutput("ackAfterRdAdr", 64'(adr_photon_rs1), 64'd0);
      @(posedge clk);
      #1;
      waitIdle();
      compareResults();

      $display("[TB] malformed command");
      runCommand(8'h60, 32'd0);
      runCommand(8'h01, 32'd0);

      $display("[TB] transmit back-pressure");
      runCommand(8'h83, 32'hDEADBEEF);
      txDelay = 5;
      runCommand(8'h03, 32'd0);
      txDelay = 0;

      $display("[TB] reset mid-write");
      applyStimulus(8'h85);
      applyStimulus(8'hA1);
      applyStimulus(8'hB2);
      Rst_n  = 1'b0;
      expErr = 1'b0;
      @(negedge clk);
      checkResetOutputs();
      @(posedge clk);
      #1;
      Rst_n = 1'b1;
      @(posedge clk);
      #1;
      runCommand(8'h05, 32'd0);

`ifdef REGBRIDGE_TIMEOUT_EN
      $display("[TB] data-byte timeout");
      expTx.push_back(NakByte);
      expErr = 1'b1;
      applyStimulus(8'h81);
      applyStimulus(8'h11);
      repeat (50) @(negedge clk);
      checkOutput("timeoutEarly", 64'(tx_valid), 64'd0);
      @(negedge clk);
      checkOutput("timeoutNak", 64'(tx_valid), 64'd1);
      @(posedge clk);
      #1;
      waitIdle();
      compareResults();
`endif

      $display("[TB] randomized commands");
      ackRandom = 1'b1;
      for (int n = 0; n < 40; n++) begin
         kind    = $urandom_range(0, 9);
         txDelay = $urandom_range(0, 2);
         word    = $urandom;
         if (kind < 4)      cmd = {1'b1, 2'b00, 5'($urandom)};
         else if (kind < 9) cmd = {1'b0, 2'b00, 5'($urandom)};
         else               cmd = {1'($urandom), 2'($urandom_range(1, 3)), 5'($urandom)};
         runCommand(cmd, word);
      end
      ackRandom = 1'b0;
      stall_ack = 1'b1;
      txDelay   = 0;

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/regfile_dbg_bridge.md
Name: regfile_dbg_bridge

Overview:
- Initiator on the photon side of the core register file: reads via the photon rs1 read port, writes via the photon write port.
- Driven by a byte stream from the UART receiver; returns response bytes to the UART transmitter.
- Stalls the core through a request/acknowledge pair before touching the register file. While stalled, the core's own rs1 address is 0, so the photon read path has priority.

Parameters:
- ACK_BYTE, 8'hAA, byte returned after a completed write
- NAK_BYTE, 8'hEE, byte returned for a malformed command
- TIMEOUT_CYCLES, 100000, maximum gap between bytes of one command (used only with the optional feature)

Ports:
- clk  in  1  system clock
- Rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  command/data byte from the UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts rx_data this cycle
- tx_data  out  8  response byte to the UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data
- stall_req  out  1  request that the core freeze the pipeline and hold adr_rs1 = 0
- stall_ack  in  1  core is frozen
- adr_photon_rs1  out  5  register read address
- photon_rs1_data  in  32  combinational read data for adr_photon_rs1
- photon_regwrite  out  1  one-cycle write strobe
- addr_corereg_photon  out  5  write address
- photon_data_out  out  32  write data
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky; set on a NAK, cleared only by reset

Behaviour:
- Reset (asynchronous, Rst_n=0): state IDLE. All outputs 0 except rx_ready=1. Any command in flight is discarded; no strobe is issued.
- Byte handshake: a byte transfers when valid & ready are both high on a clk edge. tx_data is held stable while tx_valid=1 and tx_ready=0.
- Command byte format:
  - bit7: 1 = write, 0 = read
  - bits6:5: must be 00
  - bits4:0: register index
- IDLE: rx_ready=1. On accepting a command byte:
  - bits6:5 != 00: go to RESP with NAK_BYTE and set err.
  - write: go to GETD with byte counter = 0.
  - read: go to REQ.
- GETD: rx_ready=1. Accepts 4 data bytes, least-significant byte first, into the 32-bit write-data register. After the 4th byte, go to REQ.
- REQ: stall_req=1, rx_ready=0. Wait for stall_ack=1 (no bound), then:
  - write: go to WR.
  - read: go to RD.
- WR: exactly one cycle.
  - photon_regwrite=1 with addr_corereg_photon=index and photon_data_out=word.
  - Index 0: the strobe is still issued (the register file drops it); ACK is still returned.
  - Next state: RESP with ACK_BYTE.
- RD: adr_photon_rs1=index for 1 cycle. At the end of the cycle, photon_rs1_data is captured into the shift register. Next state: SEND with count 4.
  - Index 0 reads back 0, because the register file returns 0 when both addresses are 0.
- stall_req is held from REQ through the end of WR/RD and drops the cycle after.
- adr_photon_rs1 returns to 0 whenever the state is not RD.
- SEND: tx_valid=1 with tx_data = shift register byte 0. Each accepted byte shifts the register right by 8 and decrements the count. After the 4th byte, go to IDLE.
- RESP: tx_valid=1 with the response byte; on acceptance, go to IDLE.
- rx_ready=0 in REQ, WR, RD, SEND and RESP; incoming bytes are back-pressured, never dropped.
- Latency, read command, with stall_ack already high: 1 cycle REQ, 1 cycle RD, then the first tx_valid.
- If stall_ack drops while in WR or RD, the access still completes. Core stall integrity is the core's responsibility.

Optional Feature:
- Macro: REGBRIDGE_TIMEOUT_EN.
- Defined: a counter clears on every accepted byte and increments each cycle while in GETD. On reaching TIMEOUT_CYCLES, the partial word is discarded, err is set, and the state goes to RESP with NAK_BYTE. No register is written.
- Undefined: no counter exists; GETD waits indefinitely.

Test Plan:
- Write then read: send 0x85,0x78,0x56,0x34,0x12 with stall_ack tied 1 -> one photon_regwrite pulse, addr 5, data 0x12345678; tx 0xAA. Then send 0x05 with photon_rs1_data modelled from a 32-entry array -> tx 0x78,0x56,0x34,0x12.
- Stall handshake: send read 0x02 with stall_ack held 0 for 20 cycles -> stall_req=1 throughout, adr_photon_rs1=0, no tx. When stall_ack rises -> adr_photon_rs1=2 for exactly 1 cycle, then 4 bytes out.
- Malformed command: send 0x60 -> tx 0xEE, err=1 and stays 1, no photon_regwrite, stall_req never asserted.
- Transmit back-pressure: read reg 3 = 0xDEADBEEF with tx_ready low for 5 cycles before each byte -> tx 0xEF,0xBE,0xAD,0xDE in order, each held stable; rx_ready=0 throughout.
- Reset mid-write: assert Rst_n=0 after 2 of 4 data bytes, release, then send read 0x05 -> no write strobe occurs, all outputs return to reset values, and the read returns the old register value.
- With REGBRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=50: send 0x81,0x11 then idle 60 cycles -> tx 0xEE at cycle 50 after the last byte, err=1, no photon_regwrite.
